// File: rtl/pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared pipeline-stage types, default EX/MEM widths, packing.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   localparam int EXMEM_CTRL_W = 4;
   localparam int ALU_W        = 32;
   localparam int RS2_W        = 32;
   localparam int RD_W         = 5;
   localparam int EXMEM_DATA_W = ALU_W + RS2_W + RD_W;

   function automatic logic [EXMEM_DATA_W-1:0] pack_ex_mem(
      input logic [ALU_W-1:0] alu,
      input logic [RS2_W-1:0] rs2,
      input logic [RD_W-1:0]  rd
   );
      return {alu, rs2, rd};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +--------------------------------------------------------------------------+
// | sat_counter : event counter that sticks at all-ones, cleared by rst only. |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != C_MAX)) begin
         cnt_d = cnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_skid_stage.sv
// +--------------------------------------------------------------------------+
// | ex_mem_skid_stage : valid/ready pipeline register with 2-entry skid,      |
// |                     flush-over-stall priority and saturating counters.    |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module ex_mem_skid_stage
   import pipe_pkg::*;
#(
   parameter int CTRL_W = EXMEM_CTRL_W,
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   stage_state_e      state_q;
   logic [CTRL_W-1:0] head_ctrl_q;
   logic [DATA_W-1:0] head_data_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;

   logic head_valid;
   logic acc;
   logic iss;

   // Ready looks only at registered state and stall, never at out_ready.
   assign head_valid = (state_q != ST_EMPTY);
   assign in_ready   = ~stall_i & (state_q != ST_FULL);
   assign out_valid  = head_valid & ~stall_i;
   assign acc        = in_valid & in_ready;
   assign iss        = out_valid & out_ready;

   assign out_ctrl   = head_ctrl_q;
   assign out_data   = head_data_q;

   // Head registers are zeroed whenever the stage empties, so a bubble reads as 0.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         state_q     <= ST_EMPTY;
         head_ctrl_q <= '0;
         head_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  head_ctrl_q <= in_ctrl;
                  head_data_q <= in_data;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (acc && iss) begin
                  head_ctrl_q <= in_ctrl;
                  head_data_q <= in_data;
               end else if (iss) begin
                  head_ctrl_q <= '0;
                  head_data_q <= '0;
                  state_q     <= ST_EMPTY;
               end else if (acc) begin
                  skid_ctrl_q <= in_ctrl;
                  skid_data_q <= in_data;
                  state_q     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (iss) begin
                  head_ctrl_q <= skid_ctrl_q;
                  head_data_q <= skid_data_q;
                  skid_ctrl_q <= '0;
                  skid_data_q <= '0;
                  state_q     <= ST_ONE;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (head_valid & (stall_i | ~out_ready)),
      .cnt (stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_i),
      .cnt (flush_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_skid_stage.sv
// +--------------------------------------------------------------------------+
// | tb_ex_mem_skid_stage : directed self-checking bench for the skid stage.   |
// | Revision             : 1.0                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ex_mem_skid_stage;
   import pipe_pkg::*;

   localparam int CTRL_W = 4;
   localparam int DATA_W = 69;
   localparam int CNT_W  = 16;
   localparam int SAT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              stall_i;
   logic              flush_i;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   logic              s_in_ready;
   logic              s_out_valid;
   logic [CTRL_W-1:0] s_out_ctrl;
   logic [DATA_W-1:0] s_out_data;
   logic [SAT_W-1:0]  s_stall_cnt;
   logic [SAT_W-1:0]  s_flush_cnt;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ex_mem_skid_stage #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stall_i   (stall_i),
      .flush_i   (flush_i),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   // Narrow-counter copy driven by the same stimulus, used for saturation.
   ex_mem_skid_stage #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .CNT_W  (SAT_W)
   ) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (s_in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (s_out_valid),
      .out_ready (out_ready),
      .out_ctrl  (s_out_ctrl),
      .out_data  (s_out_data),
      .stall_i   (stall_i),
      .flush_i   (flush_i),
      .stall_cnt (s_stall_cnt),
      .flush_cnt (s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input int d);
      in_valid = v;
      in_ctrl  = c;
      in_data  = DATA_W'(d);
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      stall_i   = 1'b0;
      flush_i   = 1'b0;
      in_valid  = 1'b1;
      in_ctrl   = 4'hA;
      in_data   = pack_ex_mem(32'd0, 32'd0, 5'd1);

      // Reset held two edges with a beat waiting at the input.
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      rst = 1'b0;
      settle();
      chk("rst_in_ready", in_ready, 1);
      tick();
      drive(1'b0, 4'h0, 0);
      settle();
      chk("first_out_valid", out_valid, 1);
      chk("first_out_ctrl", out_ctrl, 4'hA);
      chk("first_out_data", out_data, 1);
      tick();
      chk("first_drained", out_valid, 0);

      // Streaming: 8 back-to-back beats.
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) drive(1'b1, CTRL_W'(i), i);
         else        drive(1'b0, 4'h0, 0);
         settle();
         if (i <= 8) chk("stream_in_ready", in_ready, 1);
         if (i > 1) begin
            chk("stream_out_valid", out_valid, 1);
            chk("stream_out_data", out_data, i - 1);
            chk("stream_out_ctrl", out_ctrl, i - 1);
         end
         tick();
      end
      chk("stream_drained", out_valid, 0);
      chk("stream_stall_cnt", stall_cnt, 0);

      // Back-pressure: beats 1,2 fill head+skid, beat 3 waits.
      out_ready = 1'b0;
      drive(1'b1, 4'h1, 1);
      settle();
      chk("bp_ready_b1", in_ready, 1);
      tick();
      drive(1'b1, 4'h2, 2);
      settle();
      chk("bp_ready_b2", in_ready, 1);
      tick();
      drive(1'b1, 4'h3, 3);
      settle();
      chk("bp_ready_b3_blocked", in_ready, 0);
      tick();
      out_ready = 1'b1;
      settle();
      chk("bp_still_full", in_ready, 0);
      chk("bp_deliver1", out_data, 1);
      tick();
      settle();
      chk("bp_ready_after", in_ready, 1);
      chk("bp_deliver2", out_data, 2);
      tick();
      drive(1'b0, 4'h0, 0);
      settle();
      chk("bp_deliver3", out_data, 3);
      chk("bp_deliver3_valid", out_valid, 1);
      tick();
      chk("bp_drained", out_valid, 0);
      chk("bp_stall_cnt", stall_cnt, 2);

      // Flush while FULL, with a stalled input beat 9 present.
      out_ready = 1'b0;
      drive(1'b1, 4'h6, 6);
      tick();
      drive(1'b1, 4'h7, 7);
      tick();
      drive(1'b1, 4'h9, 9);
      stall_i = 1'b1;
      flush_i = 1'b1;
      settle();
      chk("fl_in_ready", in_ready, 0);
      chk("fl_out_valid_stalled", out_valid, 0);
      tick();
      stall_i   = 1'b0;
      flush_i   = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 4'h0, 0);
      settle();
      chk("fl_out_valid", out_valid, 0);
      chk("fl_out_ctrl", out_ctrl, 0);
      chk("fl_out_data", out_data, 0);
      chk("fl_in_ready_after", in_ready, 1);
      chk("fl_flush_cnt", flush_cnt, 1);
      chk("fl_stall_cnt", stall_cnt, 4);
      tick();
      chk("fl_beat9_absent", out_valid, 0);
      chk("fl_sat_flush_cnt", s_flush_cnt, 1);

      // Mid-run reset clears counters.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_stall_cnt", stall_cnt, 0);
      chk("rst2_flush_cnt", flush_cnt, 0);

      // Stall for 3 cycles with head = 5.
      drive(1'b1, 4'h5, 5);
      tick();
      drive(1'b0, 4'h0, 0);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("st_out_valid", out_valid, 0);
         chk("st_in_ready", in_ready, 0);
         tick();
      end
      stall_i = 1'b0;
      settle();
      chk("st_release_valid", out_valid, 1);
      chk("st_release_data", out_data, 5);
      tick();
      chk("st_once", out_valid, 0);
      chk("st_stall_cnt", stall_cnt, 3);

      // Saturation: 6 stalled cycles on the 2-bit counter copy.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 4'hC, 12);
      tick();
      drive(1'b0, 4'h0, 0);
      stall_i = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      stall_i = 1'b0;
      chk("sat_stall_cnt", s_stall_cnt, 3);
      chk("sat_wide_stall_cnt", stall_cnt, 6);
      settle();
      chk("sat_head_data", s_out_data, 12);
      tick();
      chk("sat_drained", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised, handshaked successor of the fixed EX/MEM pipeline register. It sits between any two pipeline stages (EX→MEM by default) and carries a control field and a data field. It uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates a beat. It adds a defined flush-over-stall priority, explicit bubble insertion, and saturating stall/flush event counters for performance debug.

## Interface
- CTRL_W, 4, width of control field; zeroed on flush and reset.
- DATA_W, 69, width of payload (ALU result 32 + RS2 32 + RD addr 5 by default); zeroed on flush and reset.
- CNT_W, 16, width of each saturating event counter.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; = ~stall_i & (state != FULL).
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid; = head_valid & ~stall_i.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control field (registered).
- out_data  out  DATA_W  head payload (registered).
- stall_i  in  1  freeze: no accept, no issue, contents held.
- flush_i  in  1  discard all held beats and any same-cycle input beat.
- stall_cnt  out  CNT_W  cycles with head_valid & (stall_i | ~out_ready).
- flush_cnt  out  CNT_W  number of cycles with flush_i asserted.

## Operation
- Two entries: head (drives outputs) and skid. State is EMPTY (no valid entries), ONE (head valid), or FULL (head and skid valid).
- acc = in_valid & in_ready; iss = out_valid & out_ready.
- Priority per cycle: rst > flush_i > normal handshake. stall_i is folded into acc/iss through in_ready/out_valid.
- EMPTY: if acc, load head → ONE.
- ONE:
  - acc & iss: head ← input, stay ONE.
  - iss only → EMPTY.
  - acc only: skid ← input → FULL.
- FULL: in_ready=0.
  - iss: head ← skid → ONE.
  - Otherwise hold.
- flush_i: head and skid valid ← 0, ctrl/data ← 0, state → EMPTY. Any same-cycle input beat is dropped. A same-cycle iss still counts as delivered downstream.
- stall_i & flush_i together: flush wins.
- Bubble: a cycle with head invalid presents out_ctrl=0, out_data=0.
- Counters saturate at 2^CNT_W−1 and never wrap. Only rst clears them; flush does not.
- Ordering: beats leave in acceptance order. No beat is lost except by flush.

## Timing
- Reset: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, flush_cnt=0. in_ready=1 the cycle after rst deasserts (if stall_i=0).
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- in_ready depends only on registered state and stall_i. There is no combinational path from out_ready to in_ready.
- out_valid/out_ctrl/out_data come from registers, gated by stall_i only.
- rst asserted mid-transfer: all entries discarded at that edge. Counters also clear.
- Flush in cycle N: out_valid=0 in cycle N+1. A new input can be accepted in cycle N+1.

## Structure
- Shared package pipe_pkg:
  - State enum (EMPTY/ONE/FULL).
  - Default widths for EX/MEM: CTRL_W=4, ALU 32, RS2 32, RD 5.
  - A packing helper for the default payload order {alu, rs2, rd}.
- One sub-module is natural: sat_counter (params CNT_W; ports clk, rst, inc, cnt). It is instantiated twice.
- The datapath is the two entry registers plus a mux. The FSM lives in the top module.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, outputs 0, counters 0. The first beat (ctrl=4'hA, data=1) appears one cycle after acceptance.
- Streaming: 8 beats, data=1..8, out_ready=1 → out_data 1..8 in consecutive cycles, in_ready never low.
- Back-pressure: out_ready=0 while sending beats 1,2,3 → beats 1,2 accepted, in_ready=0 on third. Raise out_ready → 1,2,3 delivered in order. stall_cnt equals the number of held cycles.
- Flush while FULL with in_valid=1 (data=9) and stall_i=1 → next cycle out_valid=0, ctrl/data=0, state EMPTY. Beat 9 never appears; flush_cnt=1.
- stall_i for 3 cycles with head=5, out_ready=1 → out_valid=0 and in_ready=0 throughout. After release, 5 is delivered once; stall_cnt=3.
- Saturation with CNT_W=2: 6 stalled cycles → stall_cnt stays at 3.
